// File: rtl/mfp_adc_max10_avg.sv
// -----------------------------------------------------------------------------
// mfp_adc_max10_avg
//
// Per-channel oversampling averager placed directly behind the MAX10 ADC
// response stream. Each mapped channel owns one accumulator cell; after
// 2**AVG_LOG2 samples the cell emits a single rounded 12-bit average as a
// one-cycle strobe. There is no backpressure on either side.
//
// Cell map: channels 1..6 -> cells 0..5, channel 17 (temperature) -> cell 6.
// Samples on any other channel are ignored completely.
//
// Parameters
//   AVG_LOG2       log2 of samples per average, 0..6 (0 = pass-through)
//
// Ports
//   CLK            clock, rising edge
//   RESET          synchronous active-high reset, dominant over all inputs
//   ADC_R_Valid    response sample valid
//   ADC_R_Channel  response channel number
//   ADC_R_Data     response sample, unsigned 12-bit
//   ADC_R_SOP      response start of packet (not used for averaging)
//   ADC_R_EOP      response end of packet
//   AVG_Clear      discard all partial accumulations and the packet flag
//   AVG_Valid      one-cycle strobe: new average on AVG_Channel/AVG_Data
//   AVG_Channel    channel number of the emitted average (held between strobes)
//   AVG_Data       rounded average (held between strobes)
//   AVG_PktDone    one-cycle strobe: EOP seen with >=1 average emitted in packet
// -----------------------------------------------------------------------------
module mfp_adc_max10_avg #(
   parameter int unsigned AVG_LOG2 = 3
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        ADC_R_Valid,
   input  logic [4:0]  ADC_R_Channel,
   input  logic [11:0] ADC_R_Data,
   input  logic        ADC_R_SOP,
   input  logic        ADC_R_EOP,
   input  logic        AVG_Clear,
   output logic        AVG_Valid,
   output logic [4:0]  AVG_Channel,
   output logic [11:0] AVG_Data,
   output logic        AVG_PktDone
);

   localparam int unsigned NumCells = 7;
   localparam int unsigned AccW     = 12 + AVG_LOG2;
   localparam int unsigned SumW     = 13 + AVG_LOG2;
   // A one-bit counter is kept even for AVG_LOG2 = 0 so the arrays stay legal;
   // in that build every sample is treated as the last one and cnt never moves.
   localparam int unsigned CntW     = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

   localparam logic [CntW-1:0] CntLast   = CntW'((1 << AVG_LOG2) - 1);
   // Half an LSB of the result for round-half-up; evaluates to 0 when AVG_LOG2 = 0.
   localparam logic [SumW-1:0] RoundHalf = SumW'((1 << AVG_LOG2) >> 1);

   // SOP carries no information for averaging.
   logic unused_sop;
   assign unused_sop = ADC_R_SOP;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [AccW-1:0] acc_q [NumCells];
   logic [AccW-1:0] acc_d [NumCells];
   logic [CntW-1:0] cnt_q [NumCells];
   logic [CntW-1:0] cnt_d [NumCells];

   logic            pkt_hit_q,     pkt_hit_d;
   logic            avg_valid_q,   avg_valid_d;
   logic [4:0]      avg_channel_q, avg_channel_d;
   logic [11:0]     avg_data_q,    avg_data_d;
   logic            pkt_done_q,    pkt_done_d;

   // ---------------------------------------------------------------------------
   // Channel to cell decode
   // ---------------------------------------------------------------------------
   logic       cell_hit;
   logic [2:0] cell_idx;

   always_comb begin
      cell_hit = 1'b1;
      cell_idx = 3'd0;
      case (ADC_R_Channel)
         5'd1:    cell_idx = 3'd0;
         5'd2:    cell_idx = 3'd1;
         5'd3:    cell_idx = 3'd2;
         5'd4:    cell_idx = 3'd3;
         5'd5:    cell_idx = 3'd4;
         5'd6:    cell_idx = 3'd5;
         5'd17:   cell_idx = 3'd6;
         default: cell_hit = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Sample acceptance and completion
   // ---------------------------------------------------------------------------
   logic            accept;
   logic            is_last;
   logic            complete;
   logic [SumW-1:0] sum;
   logic [SumW-1:0] rounded;

   always_comb begin
      accept   = ADC_R_Valid & cell_hit & ~AVG_Clear;
      is_last  = (AVG_LOG2 == 0) ? 1'b1 : (cnt_q[cell_idx] == CntLast);
      complete = accept & is_last;
      // Max sum is 4095 * 2**AVG_LOG2, so the rounded shift never exceeds 4095.
      sum      = SumW'(acc_q[cell_idx]) + SumW'(ADC_R_Data);
      rounded  = sum + RoundHalf;
   end

   // ---------------------------------------------------------------------------
   // Next-state: accumulators and counters
   // ---------------------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < NumCells; i++) begin
         acc_d[i] = acc_q[i];
         cnt_d[i] = cnt_q[i];
      end
      if (AVG_Clear) begin
         for (int i = 0; i < NumCells; i++) begin
            acc_d[i] = '0;
            cnt_d[i] = '0;
         end
      end else if (accept) begin
         if (is_last) begin
            acc_d[cell_idx] = '0;
            cnt_d[cell_idx] = '0;
         end else begin
            acc_d[cell_idx] = acc_q[cell_idx] + AccW'(ADC_R_Data);
            cnt_d[cell_idx] = cnt_q[cell_idx] + CntW'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state: outputs and packet tracking
   // ---------------------------------------------------------------------------
   always_comb begin
      avg_valid_d   = complete;
      avg_channel_d = avg_channel_q;
      avg_data_d    = avg_data_q;
      if (complete) begin
         avg_channel_d = ADC_R_Channel;
         avg_data_d    = 12'(rounded >> AVG_LOG2);
      end

      // EOP only counts on an accepted sample; an EOP on an unmapped channel
      // or alongside AVG_Clear is dropped with the sample.
      pkt_done_d = accept & ADC_R_EOP & (pkt_hit_q | complete);

      pkt_hit_d = pkt_hit_q;
      if (AVG_Clear) begin
         pkt_hit_d = 1'b0;
      end else if (accept && ADC_R_EOP) begin
         pkt_hit_d = 1'b0;
      end else if (complete) begin
         pkt_hit_d = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < NumCells; i++) begin
            acc_q[i] <= '0;
            cnt_q[i] <= '0;
         end
         pkt_hit_q     <= 1'b0;
         avg_valid_q   <= 1'b0;
         avg_channel_q <= '0;
         avg_data_q    <= '0;
         pkt_done_q    <= 1'b0;
      end else begin
         for (int i = 0; i < NumCells; i++) begin
            acc_q[i] <= acc_d[i];
            cnt_q[i] <= cnt_d[i];
         end
         pkt_hit_q     <= pkt_hit_d;
         avg_valid_q   <= avg_valid_d;
         avg_channel_q <= avg_channel_d;
         avg_data_q    <= avg_data_d;
         pkt_done_q    <= pkt_done_d;
      end
   end

   assign AVG_Valid   = avg_valid_q;
   assign AVG_Channel = avg_channel_q;
   assign AVG_Data    = avg_data_q;
   assign AVG_PktDone = pkt_done_q;

endmodule

// File: tb/tb_mfp_adc_max10_avg.sv
// -----------------------------------------------------------------------------
// tb_mfp_adc_max10_avg
//
// Directed bench for the ADC averager. Two instances share all inputs: one
// with AVG_LOG2 = 3 (main checks) and one with AVG_LOG2 = 0 (pass-through).
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge, so each row's expectation is the registered result of
// that row's inputs.
// -----------------------------------------------------------------------------
module tb_mfp_adc_max10_avg;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [4:0]  ch;
   logic [11:0] data;
   logic        sop;
   logic        eop;
   logic        clr;

   logic        o_valid,  z_valid;
   logic [4:0]  o_ch,     z_ch;
   logic [11:0] o_data,   z_data;
   logic        o_pkt,    z_pkt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mfp_adc_max10_avg #(.AVG_LOG2(3)) dut (
      .CLK           (clk),
      .RESET         (rst),
      .ADC_R_Valid   (valid),
      .ADC_R_Channel (ch),
      .ADC_R_Data    (data),
      .ADC_R_SOP     (sop),
      .ADC_R_EOP     (eop),
      .AVG_Clear     (clr),
      .AVG_Valid     (o_valid),
      .AVG_Channel   (o_ch),
      .AVG_Data      (o_data),
      .AVG_PktDone   (o_pkt)
   );

   mfp_adc_max10_avg #(.AVG_LOG2(0)) dut0 (
      .CLK           (clk),
      .RESET         (rst),
      .ADC_R_Valid   (valid),
      .ADC_R_Channel (ch),
      .ADC_R_Data    (data),
      .ADC_R_SOP     (sop),
      .ADC_R_EOP     (eop),
      .AVG_Clear     (clr),
      .AVG_Valid     (z_valid),
      .AVG_Channel   (z_ch),
      .AVG_Data      (z_data),
      .AVG_PktDone   (z_pkt)
   );

   typedef struct {
      logic        v;
      logic [4:0]  ch;
      logic [11:0] d;
      logic        eop;
      logic        clr;
      logic        ev;
      logic [4:0]  ech;
      logic [11:0] ed;
      logic        epd;
   } vec_t;

   vec_t        vecs[$];
   logic [4:0]  hold_ch = '0;
   logic [11:0] hold_d  = '0;

   // Channel/data expectations carry the last expected average between strobes.
   function automatic void add(input logic v, input int c, input int d, input logic e,
                               input logic cl, input logic ev, input int ech, input int ed,
                               input logic epd);
      vec_t r;
      if (ev) begin
         hold_ch = 5'(ech);
         hold_d  = 12'(ed);
      end
      r.v   = v;
      r.ch  = 5'(c);
      r.d   = 12'(d);
      r.eop = e;
      r.clr = cl;
      r.ev  = ev;
      r.ech = hold_ch;
      r.ed  = hold_d;
      r.epd = epd;
      vecs.push_back(r);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_main(input string name, input logic ev, input int ech, input int ed,
                           input logic epd);
      chk({name, ".valid"},   int'(o_valid), int'(ev));
      chk({name, ".channel"}, int'(o_ch),    ech);
      chk({name, ".data"},    int'(o_data),  ed);
      chk({name, ".pktdone"}, int'(o_pkt),   int'(epd));
   endtask

   task automatic chk_zero(input string name, input logic ev, input int ech, input int ed,
                           input logic epd);
      chk({name, ".p0_valid"},   int'(z_valid), int'(ev));
      chk({name, ".p0_channel"}, int'(z_ch),    ech);
      chk({name, ".p0_data"},    int'(z_data),  ed);
      chk({name, ".p0_pktdone"}, int'(z_pkt),   int'(epd));
   endtask

   task automatic apply(input logic v, input int c, input int d, input logic e,
                        input logic cl);
      @(negedge clk);
      valid = v;
      ch    = 5'(c);
      data  = 12'(d);
      eop   = e;
      clr   = cl;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst   = 1'b1;
      valid = 1'b0;
      ch    = '0;
      data  = '0;
      sop   = 1'b0;
      eop   = 1'b0;
      clr   = 1'b0;

      // Reset dominates a concurrent valid sample.
      apply(1'b1, 1, 100, 1'b1, 1'b0);
      apply(1'b1, 1, 100, 1'b1, 1'b0);
      chk_main("reset", 1'b0, 0, 0, 1'b0);
      chk_zero("reset", 1'b0, 0, 0, 1'b0);
      rst = 1'b0;

      // Ramp 100..107 on ch1: sum 828, (828+4)>>3 = 104.
      for (int i = 0; i < 8; i++) add(1, 1, 100 + i, 0, 0, i == 7, 1, 104, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Interleaved full-scale ch2 and zero ch17: consecutive strobes.
      for (int i = 0; i < 8; i++) begin
         add(1, 2, 4095, 0, 0, i == 7, 2, 4095, 0);
         add(1, 17, 0, 0, 0, i == 7, 17, 0, 0);
      end
      add(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Unmapped channels mid-accumulation must not advance cnt or add data.
      for (int i = 0; i < 4; i++) add(1, 1, 50, 0, 0, 0, 0, 0, 0);
      add(1, 0, 4095, 0, 0, 0, 0, 0, 0);
      add(1, 7, 4095, 0, 0, 0, 0, 0, 0);
      add(1, 18, 4095, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) add(1, 1, 50, 0, 0, i == 3, 1, 50, 0);

      // Packet of ch1..6 x 8 rounds: ch k sees 10k+r, average 10k+4.
      for (int r = 0; r < 8; r++) begin
         for (int k = 1; k <= 6; k++) begin
            add(1, k, 10 * k + r, (r == 7) && (k == 6), 0, r == 7, k, 10 * k + 4,
                (r == 7) && (k == 6));
         end
      end
      // Next packet only leaves partial sums: no PktDone.
      add(1, 1, 5, 0, 0, 0, 0, 0, 0);
      add(1, 2, 5, 0, 0, 0, 0, 0, 0);
      add(1, 3, 5, 1, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0);

      foreach (vecs[i]) begin
         apply(vecs[i].v, int'(vecs[i].ch), int'(vecs[i].d), vecs[i].eop, vecs[i].clr);
         chk_main($sformatf("vec%0d", i), vecs[i].ev, int'(vecs[i].ech), int'(vecs[i].ed),
                  vecs[i].epd);
      end

      // AVG_Clear with a concurrent sample, after partial ch3 sums (ch3 holds
      // one leftover sample from the previous packet).
      for (int i = 0; i < 4; i++) begin
         apply(1'b1, 3, 10, 1'b0, 1'b0);
         chk_main("pre_clear", 1'b0, 6, 64, 1'b0);
      end
      apply(1'b1, 3, 10, 1'b0, 1'b1);
      chk_main("clear", 1'b0, 6, 64, 1'b0);
      for (int i = 0; i < 8; i++) begin
         apply(1'b1, 3, 20, 1'b0, 1'b0);
         if (i == 7) chk_main("post_clear_avg", 1'b1, 3, 20, 1'b0);
         else        chk_main("post_clear", 1'b0, 6, 64, 1'b0);
      end

      // Reset mid-accumulation loses the partial ch4 sum.
      for (int i = 0; i < 5; i++) apply(1'b1, 4, 4095, 1'b0, 1'b0);
      chk_main("pre_reset", 1'b0, 3, 20, 1'b0);
      rst = 1'b1;
      apply(1'b0, 0, 0, 1'b0, 1'b0);
      chk_main("mid_reset", 1'b0, 0, 0, 1'b0);
      chk_zero("mid_reset", 1'b0, 0, 0, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         apply(1'b1, 4, 7, 1'b0, 1'b0);
         if (i == 7) chk_main("post_reset_avg", 1'b1, 4, 7, 1'b0);
         else        chk_main("post_reset", 1'b0, 0, 0, 1'b0);
      end

      // Pass-through build echoes each accepted sample one cycle later.
      apply(1'b1, 5, 123, 1'b0, 1'b0);
      chk_zero("p0_echo", 1'b1, 5, 123, 1'b0);
      apply(1'b1, 7, 9, 1'b0, 1'b0);
      chk_zero("p0_unmapped", 1'b0, 5, 123, 1'b0);
      apply(1'b1, 17, 4095, 1'b0, 1'b0);
      chk_zero("p0_temp", 1'b1, 17, 4095, 1'b0);
      apply(1'b1, 1, 5, 1'b0, 1'b1);
      chk_zero("p0_clear", 1'b0, 17, 4095, 1'b0);
      apply(1'b1, 2, 1, 1'b1, 1'b0);
      chk_zero("p0_eop", 1'b1, 2, 1, 1'b1);
      apply(1'b0, 0, 0, 1'b0, 1'b0);
      chk_zero("p0_idle", 1'b0, 2, 1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
